mem_stage_ctrl: RTL

Sequencing controller for the MEM stage of the 5-stage RISC-V pipeline. It takes the memory-access controls and operands held in the EX/MEM pipeline register and drives a variable-latency data memory over a req/ack handshake. While an access is outstanding it raises a global stall that freezes PC, IF/ID, ID/EX and EX/MEM. It also flags misaligned and timed-out accesses.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/mem_stage_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline: data-path width,
// MEM-stage controller state encoding and word-alignment helpers.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // Low address bits that must be zero for a naturally aligned word access.
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'h0000_0003;

    // MEM-stage sequencing states, 2-bit encoding.
    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_DONE = 2'd2
    } mem_state_e;

    // True when a byte address is not word aligned.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr & ALIGN_MASK) != '0;
    endfunction

endpackage : riscv_pkg

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencing controller. Takes the load/store controls and operands
// held in EX/MEM, runs one access at a time against a variable-latency data
// memory over a req/ack handshake, stalls the upstream pipeline while the
// access is outstanding, and reports misaligned or timed-out accesses.
module mem_stage_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16  // max REQ cycles without ack, 2..255
) (
    input  logic            clk_i,
    input  logic            rst_i,        // asynchronous, active-low

    // EX/MEM pipeline register
    input  logic            MemRead_i,
    input  logic            MemWrite_i,
    input  logic [XLEN-1:0] ALUResult_i,
    input  logic [XLEN-1:0] ALUinB_i,

    // Data memory handshake
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_ack_i,
    input  logic [XLEN-1:0] mem_rdata_i,

    // Pipeline control / MEM/WB
    output logic            stall_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            err_o
);

    // Counter value on the last REQ cycle an ack is still accepted.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    mem_state_e      state_q, state_d;
    logic [7:0]      cnt_q,   cnt_d;
    logic            tmo_q,   tmo_d;
    logic            we_q,    we_d;
    logic [XLEN-1:0] addr_q,  addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic access;
    logic misaligned;
    logic idle_start;
    logic idle_fault;

    // Decode the instruction currently sitting in EX/MEM.
    always_comb begin
        access     = MemRead_i | MemWrite_i;
        misaligned = access & is_misaligned(ALUResult_i);
        idle_start = (state_q == MS_IDLE) & access & ~misaligned;
        idle_fault = (state_q == MS_IDLE) & misaligned;
    end

    // Next-state and datapath latch logic for the access sequencer.
    always_comb begin
        // NOTE: every _d starts as its _q so each path through the case
        // assigns it and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            MS_IDLE: begin
                // A misaligned access never leaves IDLE; its fault is flagged
                // combinationally below. Acks seen here are ignored.
                if (idle_start) begin
                    addr_d  = ALUResult_i;
                    wdata_d = ALUinB_i;
                    we_d    = MemWrite_i;
                    cnt_d   = '0;
                    state_d = MS_REQ;
                end
            end

            MS_REQ: begin
                if (mem_ack_i) begin
                    // A store completes without disturbing the last load result.
                    if (!we_q) begin
                        rdata_d = mem_rdata_i;
                    end
                    state_d = MS_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    rdata_d = '0;
                    state_d = MS_DONE;
                end else if (cnt_q != 8'hFF) begin
                    // Saturate rather than wrap.
                    cnt_d = cnt_q + 8'd1;
                end
            end

            MS_DONE: begin
                tmo_d   = 1'b0;
                state_d = MS_IDLE;
            end

            default: begin
                state_d = MS_IDLE;
            end
        endcase
    end

    // State and latched-operand registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of its _d regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Output decode. The request is taken straight from the state register so
    // an asynchronous reset drops it immediately; stall is combinational so
    // EX/MEM freezes in the same cycle an access is detected.
    always_comb begin
        mem_req_o   = (state_q == MS_REQ);
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        stall_o     = idle_start | (state_q == MS_REQ);
        err_o       = idle_fault | ((state_q == MS_DONE) & tmo_q);
        rdata_o     = idle_fault ? '0 : rdata_q;
    end

endmodule : mem_stage_ctrl
